wb_register_file: RTL

Write-back stage and architectural register file of the five-stage MIPS pipeline. It sits directly downstream of the MEM/WB pipeline register. It selects the write-back value, either the loaded memory word or the ALU result/address, and commits it to the 32-entry register file on the clock edge. It serves the two decode-stage read ports, with same-cycle write-through bypass, and exports the write-back value for EX-stage forwarding.

---
 rtl/wb_register_file_if.sv | 29 ++
 rtl/wb_register_file.sv | 50 +++++
 2 files changed

// File: rtl/wb_register_file_if.sv
// MEM/WB-to-register-file bus: write-back controls and data in, decode read ports and forwarding value out.
interface wb_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_write_in;
    logic                  mem_to_reg_in;
    logic [ADDR_WIDTH-1:0] write_back_destination_in;
    logic [DATA_WIDTH-1:0] read_data_in;
    logic [DATA_WIDTH-1:0] address_in;
    logic [ADDR_WIDTH-1:0] read_reg_1;
    logic [ADDR_WIDTH-1:0] read_reg_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic [DATA_WIDTH-1:0] write_back_data_out;
    logic                  write_back_valid_out;

    modport master (
        output reg_write_in, mem_to_reg_in, write_back_destination_in,
               read_data_in, address_in, read_reg_1, read_reg_2,
        input  read_data_1, read_data_2, write_back_data_out, write_back_valid_out
    );

    modport slave (
        input  reg_write_in, mem_to_reg_in, write_back_destination_in,
               read_data_in, address_in, read_reg_1, read_reg_2,
        output read_data_1, read_data_2, write_back_data_out, write_back_valid_out
    );
endinterface

// File: rtl/wb_register_file.sv
// Write-back mux plus 32-entry architectural register file with $0 hardwired and same-cycle write-through reads.
module wb_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    wb_register_file_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  we;

    assign wb_data = bus.mem_to_reg_in ? bus.read_data_in : bus.address_in;
    assign we      = bus.reg_write_in && (bus.write_back_destination_in != '0) && !reset;

    assign bus.write_back_data_out  = wb_data;
    assign bus.write_back_valid_out = we;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[bus.write_back_destination_in] <= wb_data;
        end
    end

    // Bypass uses the gated enable, so reset or a $0 destination never forwards.
    always_comb begin
        bus.read_data_1 = regs_q[bus.read_reg_1];
        if (bus.read_reg_1 == '0) begin
            bus.read_data_1 = '0;
        end else if (we && (bus.read_reg_1 == bus.write_back_destination_in)) begin
            bus.read_data_1 = wb_data;
        end
    end

    always_comb begin
        bus.read_data_2 = regs_q[bus.read_reg_2];
        if (bus.read_reg_2 == '0) begin
            bus.read_data_2 = '0;
        end else if (we && (bus.read_reg_2 == bus.write_back_destination_in)) begin
            bus.read_data_2 = wb_data;
        end
    end
endmodule
